branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_pkg.sv | 9 +
 rtl/btb_storage.sv | 52 +++++
 rtl/branch_target_buffer.sv | 87 ++++++++
 tb/tb_branch_target_buffer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared branch-predictor constants, counter encodings and BTB defaults.
package branch_pkg;
    localparam logic [1:0] CTRL_SNT = 2'b00;
    localparam logic [1:0] CTRL_WNT = 2'b01;
    localparam logic [1:0] CTRL_WT  = 2'b10;
    localparam logic [1:0] CTRL_ST  = 2'b11;
    localparam int BTB_DEPTH = 16;
    localparam int BTB_PC_W  = 32;
endpackage

// File: rtl/btb_storage.sv
// btb_storage: BTB entry arrays with one asynchronous read port, one write port and a one-cycle flush.
module btb_storage
    import branch_pkg::*;
#(
    parameter int DEPTH = BTB_DEPTH,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int TAG_W = BTB_PC_W - 2 - IDX_W,
    parameter int PC_W  = BTB_PC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [PC_W-1:0]  rd_target_o,
    output logic [1:0]       rd_ctrl_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [PC_W-1:0]  wr_target_i,
    input  logic [1:0]       wr_ctrl_i,
    input  logic             flush_i
);
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [PC_W-1:0]  target_q [DEPTH];
    logic [1:0]       ctrl_q   [DEPTH];

    // Flush wins over a simultaneous write, so the write is dropped entirely.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) valid_d = '0;
        else if (wr_en_i) valid_d[wr_idx_i] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) valid_q <= '0;
        else valid_q <= valid_d;

    // Payload arrays are don't-care while invalid, so they carry no reset.
    always_ff @(posedge clk)
        if (wr_en_i && !flush_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
            ctrl_q[wr_idx_i]   <= wr_ctrl_i;
        end

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];
    assign rd_ctrl_o   = ctrl_q[rd_idx_i];
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 1-cycle registered lookup.
// Define BTB_WRITE_BYPASS_EN to forward a same-cycle write to a matching lookup.
module branch_target_buffer
    import branch_pkg::*;
#(
    parameter int DEPTH = BTB_DEPTH,
    parameter int PC_W  = BTB_PC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] PcIn,
    output logic            PcMatchValid,
    output logic [PC_W-1:0] PredTarget,
    output logic [1:0]      PredCtrl,
    output logic            PredTaken,
    input  logic            WriteEnable,
    input  logic [PC_W-1:0] WrPc,
    input  logic [PC_W-1:0] WrTarget,
    input  logic [1:0]      WrCtrl,
    input  logic            FlushAll
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = PC_W - 2 - IDX_W;

    logic [IDX_W-1:0] pc_idx, wr_idx;
    logic [TAG_W-1:0] pc_tag, wr_tag, rd_tag;
    logic             rd_valid, rd_hit, byp;
    logic [PC_W-1:0]  rd_target;
    logic [1:0]       rd_ctrl;
    logic             hit_q, hit_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             unused_pc_lsbs;

    assign pc_idx = PcIn[2+IDX_W-1:2];
    assign pc_tag = PcIn[PC_W-1:2+IDX_W];
    assign wr_idx = WrPc[2+IDX_W-1:2];
    assign wr_tag = WrPc[PC_W-1:2+IDX_W];
    assign unused_pc_lsbs = ^{PcIn[1:0], WrPc[1:0]};

    btb_storage #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W), .PC_W(PC_W)) u_storage (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (pc_idx),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_target_o (rd_target),
        .rd_ctrl_o   (rd_ctrl),
        .wr_en_i     (WriteEnable),
        .wr_idx_i    (wr_idx),
        .wr_tag_i    (wr_tag),
        .wr_target_i (WrTarget),
        .wr_ctrl_i   (WrCtrl),
        .flush_i     (FlushAll)
    );

    assign rd_hit = rd_valid && (rd_tag == pc_tag);

`ifdef BTB_WRITE_BYPASS_EN
    // A write dropped by a simultaneous flush is not forwarded either.
    assign byp = WriteEnable && !FlushAll && (wr_idx == pc_idx) && (wr_tag == pc_tag);
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        hit_d    = byp || rd_hit;
        target_d = byp ? WrTarget : (rd_hit ? rd_target : '0);
        ctrl_d   = byp ? WrCtrl : (rd_hit ? rd_ctrl : CTRL_SNT);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hit_q    <= 1'b0;
            target_q <= '0;
            ctrl_q   <= CTRL_SNT;
        end else begin
            hit_q    <= hit_d;
            target_q <= target_d;
            ctrl_q   <= ctrl_d;
        end

    assign PcMatchValid = hit_q;
    assign PredTarget   = target_q;
    assign PredCtrl     = ctrl_q;
    assign PredTaken    = hit_q && ctrl_q[1];
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed self-checking bench for branch_target_buffer (DEPTH=16, PC_W=32).
module tb_branch_target_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] PcIn = '0;
    logic        PcMatchValid;
    logic [31:0] PredTarget;
    logic [1:0]  PredCtrl;
    logic        PredTaken;
    logic        WriteEnable = 1'b0;
    logic [31:0] WrPc = '0;
    logic [31:0] WrTarget = '0;
    logic [1:0]  WrCtrl = '0;
    logic        FlushAll = 1'b0;
    int errors = 0;
    int checks = 0;

    branch_target_buffer #(.DEPTH(16), .PC_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .PcIn         (PcIn),
        .PcMatchValid (PcMatchValid),
        .PredTarget   (PredTarget),
        .PredCtrl     (PredCtrl),
        .PredTaken    (PredTaken),
        .WriteEnable  (WriteEnable),
        .WrPc         (WrPc),
        .WrTarget     (WrTarget),
        .WrCtrl       (WrCtrl),
        .FlushAll     (FlushAll)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #2;
        checks++; if (PcMatchValid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", PcMatchValid); end
        checks++; if (PredTarget !== 32'h0) begin errors++; $display("FAIL rst_target got=%h exp=0", PredTarget); end
        checks++; if (PredCtrl !== 2'b00) begin errors++; $display("FAIL rst_ctrl got=%b exp=00", PredCtrl); end
        checks++; if (PredTaken !== 1'b0) begin errors++; $display("FAIL rst_taken got=%b exp=0", PredTaken); end
        @(negedge clk); rst = 1'b0; PcIn = 32'h100;
        @(posedge clk); #1;
        checks++; if (PcMatchValid !== 1'b0) begin errors++; $display("FAIL empty_valid got=%b exp=0", PcMatchValid); end
        checks++; if (PredTarget !== 32'h0) begin errors++; $display("FAIL empty_target got=%h exp=0", PredTarget); end
        checks++; if (PredTaken !== 1'b0) begin errors++; $display("FAIL empty_taken got=%b exp=0", PredTaken); end
    endtask

    task automatic test_hit();
        WriteEnable = 1'b1; WrPc = 32'h100; WrTarget = 32'h200; WrCtrl = 2'b10; PcIn = 32'h104;
        @(posedge clk); #1;
        checks++; if (PcMatchValid !== 1'b0) begin errors++; $display("FAIL other_idx_valid got=%b exp=0", PcMatchValid); end
        WriteEnable = 1'b0; PcIn = 32'h100;
        @(posedge clk); #1;
        checks++; if (PcMatchValid !== 1'b1) begin errors++; $display("FAIL hit_valid got=%b exp=1", PcMatchValid); end
        checks++; if (PredTarget !== 32'h200) begin errors++; $display("FAIL hit_target got=%h exp=200", PredTarget); end
        checks++; if (PredCtrl !== 2'b10) begin errors++; $display("FAIL hit_ctrl got=%b exp=10", PredCtrl); end
        checks++; if (PredTaken !== 1'b1) begin errors++; $display("FAIL hit_taken got=%b exp=1", PredTaken); end
    endtask

    task automatic test_alias();
        PcIn = 32'h140;
        @(posedge clk); #1;
        checks++; if (PcMatchValid !== 1'b0) begin errors++; $display("FAIL alias_valid got=%b exp=0", PcMatchValid); end
        checks++; if (PredTarget !== 32'h0) begin errors++; $display("FAIL alias_target got=%h exp=0", PredTarget); end
        checks++; if (PredCtrl !== 2'b00) begin errors++; $display("FAIL alias_ctrl got=%b exp=00", PredCtrl); end
    endtask

    task automatic test_collision();
        logic [1:0] exp_ctrl;
        logic       exp_taken;
`ifdef BTB_WRITE_BYPASS_EN
        exp_ctrl = 2'b01; exp_taken = 1'b0;
`else
        exp_ctrl = 2'b10; exp_taken = 1'b1;
`endif
        WriteEnable = 1'b1; WrPc = 32'h100; WrTarget = 32'h200; WrCtrl = 2'b01; PcIn = 32'h100;
        @(posedge clk); #1;
        checks++; if (PcMatchValid !== 1'b1) begin errors++; $display("FAIL coll_valid got=%b exp=1", PcMatchValid); end
        checks++; if (PredCtrl !== exp_ctrl) begin errors++; $display("FAIL coll_ctrl got=%b exp=%b", PredCtrl, exp_ctrl); end
        checks++; if (PredTaken !== exp_taken) begin errors++; $display("FAIL coll_taken got=%b exp=%b", PredTaken, exp_taken); end
        WriteEnable = 1'b0;
        @(posedge clk); #1;
        checks++; if (PredCtrl !== 2'b01) begin errors++; $display("FAIL coll_next_ctrl got=%b exp=01", PredCtrl); end
        checks++; if (PredTaken !== 1'b0) begin errors++; $display("FAIL coll_next_taken got=%b exp=0", PredTaken); end
    endtask

    task automatic test_second_entry();
        WriteEnable = 1'b1; WrPc = 32'h208; WrTarget = 32'habc; WrCtrl = 2'b11; PcIn = 32'h100;
        @(posedge clk); #1;
        WriteEnable = 1'b0; PcIn = 32'h208;
        @(posedge clk); #1;
        checks++; if (PredTarget !== 32'habc) begin errors++; $display("FAIL idx2_target got=%h exp=abc", PredTarget); end
        checks++; if (PredTaken !== 1'b1) begin errors++; $display("FAIL idx2_taken got=%b exp=1", PredTaken); end
        PcIn = 32'h100;
        @(posedge clk); #1;
        checks++; if (PredTarget !== 32'h200 || PredCtrl !== 2'b01) begin errors++; $display("FAIL idx0_kept got=%h/%b exp=200/01", PredTarget, PredCtrl); end
    endtask

    task automatic test_flush();
        FlushAll = 1'b1; WriteEnable = 1'b1; WrPc = 32'h180; WrTarget = 32'h300; WrCtrl = 2'b11; PcIn = 32'h100;
        @(posedge clk); #1;
        checks++; if (PcMatchValid !== 1'b1 || PredCtrl !== 2'b01) begin errors++; $display("FAIL flush_preview got=%b/%b exp=1/01", PcMatchValid, PredCtrl); end
        FlushAll = 1'b0; WriteEnable = 1'b0; PcIn = 32'h100;
        @(posedge clk); #1;
        checks++; if (PcMatchValid !== 1'b0) begin errors++; $display("FAIL flush_100 got=%b exp=0", PcMatchValid); end
        PcIn = 32'h180;
        @(posedge clk); #1;
        checks++; if (PcMatchValid !== 1'b0) begin errors++; $display("FAIL flush_180 got=%b exp=0", PcMatchValid); end
        PcIn = 32'h208;
        @(posedge clk); #1;
        checks++; if (PcMatchValid !== 1'b0) begin errors++; $display("FAIL flush_208 got=%b exp=0", PcMatchValid); end
    endtask

    task automatic test_async_reset();
        WriteEnable = 1'b1; WrPc = 32'h100; WrTarget = 32'h200; WrCtrl = 2'b11; PcIn = 32'h208;
        @(posedge clk); #1;
        WrPc = 32'h208; WrTarget = 32'h444; PcIn = 32'h100;
        @(posedge clk); #1;
        WriteEnable = 1'b0;
        checks++; if (PcMatchValid !== 1'b1 || PredTaken !== 1'b1) begin errors++; $display("FAIL pre_rst_hit got=%b/%b exp=1/1", PcMatchValid, PredTaken); end
        #2 rst = 1'b1;
        #1;
        checks++; if (PcMatchValid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", PcMatchValid); end
        checks++; if (PredTarget !== 32'h0) begin errors++; $display("FAIL arst_target got=%h exp=0", PredTarget); end
        checks++; if (PredCtrl !== 2'b00 || PredTaken !== 1'b0) begin errors++; $display("FAIL arst_ctrl got=%b/%b exp=00/0", PredCtrl, PredTaken); end
        @(negedge clk); rst = 1'b0; PcIn = 32'h100;
        @(posedge clk); #1;
        checks++; if (PcMatchValid !== 1'b0) begin errors++; $display("FAIL post_rst_100 got=%b exp=0", PcMatchValid); end
        PcIn = 32'h208;
        @(posedge clk); #1;
        checks++; if (PcMatchValid !== 1'b0) begin errors++; $display("FAIL post_rst_208 got=%b exp=0", PcMatchValid); end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_alias();
        test_collision();
        test_second_entry();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
